// File: rtl/pipe_stage_skid_reg_if.sv
// Single valid/ready/data channel between pipeline stages.
interface pipe_stage_skid_reg_if #(
  parameter int unsigned DATA_W = 110
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, flush, and valid/ready handshake.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W = 110
`ifdef PIPE_STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  flush,
  pipe_stage_skid_reg_if.slave  in_ch,
  pipe_stage_skid_reg_if.master out_ch
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_ch.valid & in_ready_q;
  assign out_fire = out_valid_q & out_ch.ready;

  assign in_ch.ready  = in_ready_q;
  assign out_ch.valid = out_valid_q;
  assign out_ch.data  = main_d;

  // out_valid_q tracks state_q != StEmpty and in_ready_q tracks state_q != StSkid,
  // kept as their own flops so both ports come straight from registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_d      <= '0;
      skid_d      <= '0;
    end else if (flush) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_d      <= '0;
      skid_d      <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StFull;
            out_valid_q <= 1'b1;
            main_d      <= in_ch.data;
          end
        end
        StFull: begin
          if (in_fire && out_fire) begin
            main_d <= in_ch.data;
          end else if (in_fire) begin
            state_q    <= StSkid;
            in_ready_q <= 1'b0;
            skid_d     <= in_ch.data;
          end else if (out_fire) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StSkid: begin
          if (out_fire) begin
            state_q    <= StFull;
            in_ready_q <= 1'b1;
            main_d     <= skid_d;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating; flush does not clear it, only clr does.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !out_ch.ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed scenarios plus a random handshake soak.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W = 110;
`ifdef PIPE_STALL_CNT_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] stall_cnt;
`endif

  logic clk = 1'b0;
  logic clr;
  logic flush;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W)) in_ch ();
  pipe_stage_skid_reg_if #(.DATA_W(DATA_W)) out_ch ();

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .in_ch (in_ch),
    .out_ch(out_ch)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected stream: every beat the stage accepts is queued; flush/clr drop what is held.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else if (in_ch.valid && in_ch.ready) begin
      exp_q.push_back(in_ch.data);
    end
  end

  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!clr) begin
      if (prev_stall && out_ch.valid) check("hold", out_ch.data, prev_data);
      if (out_ch.valid && out_ch.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", out_ch.data);
        end else begin
          check("order", out_ch.data, exp_q.pop_front());
          popped++;
        end
      end
      prev_stall = out_ch.valid && !out_ch.ready;
      prev_data  = out_ch.data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_ch.valid = 1'b1;
    in_ch.data  = d;
    tick();
    in_ch.valid = 1'b0;
  endtask

  localparam logic [DATA_W-1:0] DA = 110'h2A_AAAA_0000_1111;
  localparam logic [DATA_W-1:0] DB = 110'h3B_BBBB_0000_2222;
  localparam logic [DATA_W-1:0] DC = 110'h1C_CCCC_0000_3333;

  initial begin
    int sent;
    int cyc;
    logic fire;
    logic [DATA_W-1:0] d;

    clr = 1'b1; flush = 1'b0;
    in_ch.valid = 1'b0; in_ch.data = '0; out_ch.ready = 1'b0;
    #3;
    check("rst_out_valid", DATA_W'(out_ch.valid), '0);
    check("rst_in_ready", DATA_W'(in_ch.ready), DATA_W'(1));
    check("rst_out_data", out_ch.data, '0);
    @(negedge clk);
    clr = 1'b0;
    tick();

    // Full-rate streaming, no bubbles.
    out_ch.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_ch.valid = 1'b1;
      in_ch.data  = DATA_W'(i);
      tick();
      check("stream_in_ready", DATA_W'(in_ch.ready), DATA_W'(1));
      check("stream_out_valid", DATA_W'(out_ch.valid), DATA_W'(1));
      check("stream_out_data", out_ch.data, DATA_W'(i));
    end
    in_ch.valid = 1'b0;
    tick();
    check("stream_drained", DATA_W'(out_ch.valid), '0);

    // Back-pressure into skid, then drain.
    out_ch.ready = 1'b0;
    send(DA);
    send(DB);
    check("skid_in_ready", DATA_W'(in_ch.ready), '0);
    check("skid_out_data", out_ch.data, DA);
    tick();
    check("skid_hold", out_ch.data, DA);
    out_ch.ready = 1'b1;
    tick();
    check("drain1_data", out_ch.data, DB);
    check("drain1_in_ready", DATA_W'(in_ch.ready), DATA_W'(1));
    tick();
    check("drain2_empty", DATA_W'(out_ch.valid), '0);

    // Flush while in skid with upstream offering C.
    out_ch.ready = 1'b0;
    send(DA);
    send(DB);
    flush = 1'b1; in_ch.valid = 1'b1; in_ch.data = DC;
    tick();
    flush = 1'b0; in_ch.valid = 1'b0;
    check("flush_out_valid", DATA_W'(out_ch.valid), '0);
    check("flush_out_data", out_ch.data, '0);
    check("flush_in_ready", DATA_W'(in_ch.ready), DATA_W'(1));

    // Flush from FULL: C is accepted and discarded.
    send(DA);
    flush = 1'b1; in_ch.valid = 1'b1; in_ch.data = DC;
    tick();
    flush = 1'b0; in_ch.valid = 1'b0; out_ch.ready = 1'b1;
    tick();
    tick();
    check("flush_full_no_c", DATA_W'(out_ch.valid), '0);

    // Async clear while in skid.
    out_ch.ready = 1'b0;
    send(DA);
    send(DB);
    #2 clr = 1'b1;
    #1;
    check("clr_out_valid", DATA_W'(out_ch.valid), '0);
    check("clr_in_ready", DATA_W'(in_ch.ready), DATA_W'(1));
    check("clr_out_data", out_ch.data, '0);
    clr = 1'b0;
    tick();

`ifdef PIPE_STALL_CNT_EN
    check("cnt_zero", DATA_W'(stall_cnt), '0);
    send(DA);
    tick(); tick(); tick();
    check("cnt_three", DATA_W'(stall_cnt), DATA_W'(3));
    for (int i = 0; i < 17; i++) tick();
    check("cnt_sat", DATA_W'(stall_cnt), DATA_W'(15));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cnt_flush_keeps", DATA_W'(stall_cnt), DATA_W'(15));
    #2 clr = 1'b1;
    #1 clr = 1'b0;
    check("cnt_clr", DATA_W'(stall_cnt), '0);
    tick();
`endif

    // Random handshake soak.
    sent = 0;
    cyc  = 0;
    popped = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_ch.valid  = 1'($urandom_range(0, 1));
      out_ch.ready = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      d[31:0] = 32'(sent);
      in_ch.data = d;
      fire = in_ch.valid && in_ch.ready;
      tick();
      if (fire) sent++;
      cyc++;
    end
    in_ch.valid  = 1'b0;
    out_ch.ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    check("soak_sent", DATA_W'(sent), DATA_W'(10000));
    check("soak_popped", DATA_W'(popped), DATA_W'(10000));
    check("soak_queue_empty", DATA_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
